svn_scan_rdr: RTL and testbench
===============================

# svn_scan_rdr

Seven-segment scan reader: the receive end of the multiplexed seven-segment display bus driven by the team's segment decoder and digit scanner. It watches the active-low anode strobes and the segment lines {CA..CG,DP}, waits for each strobed pattern to be stable, and decodes the segment pattern back into a per-digit nibble, blank flag and decimal-point bit. It is used in self-check builds and in board-level loopback, where it sits beside the display driver.

## Interface
- NDIG, 4: number of multiplexed digits (2..8)
- STABLE_CYC, 4: consecutive identical samples required before a capture (2..255)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- an  in  NDIG  anode strobes, active-low; exactly one low selects a digit
- seg  in  8  {CA,CB,CC,CD,CE,CF,CG,DP}, active-low (bit 7 = CA, bit 0 = DP)
- digits  out  4*NDIG  decoded nibble per digit; digit i occupies [4i+3:4i]
- blank  out  NDIG  digit i last captured as all-segments-off
- dp  out  NDIG  decimal point of digit i, active-high (= ~DP at capture)
- valid  out  NDIG  digit i captured at least once since reset (sticky)
- upd  out  1  one-cycle pulse on every capture, legal or not
- upd_idx  out  $clog2(NDIG)  index of the digit captured with upd
- err  out  1  one-cycle pulse with upd when the pattern is illegal

## Operation
- Sample register in_q <= {an,seg} every edge. Counter cnt (8 bit):
  - cnt <= 0 when {an,seg} != in_q.
  - otherwise cnt increments, saturating at STABLE_CYC-1.
- Capture condition: {an,seg}==in_q, cnt==STABLE_CYC-2, and an is one-hot-low. Saturation guarantees exactly one capture per stable period.
- If an is all-ones or has more than one bit low (ghost, or blanking gap), the counter still runs but no capture, upd or err is produced.
- Decode of {CA..CG}, where 0 means the segment is lit:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111111→blank (digits field written 0, blank=1)
- Legal capture on digit i: writes digits[i], blank[i] and dp[i]; sets valid[i]; pulses upd with upd_idx=i.
- Illegal pattern: digits[i], blank[i] and dp[i] are unchanged, valid[i] is unchanged, and upd and err pulse together.
- Reset values: digits=0, blank=all 1, dp=0, valid=0, upd=0, upd_idx=0, err=0, in_q=all 1, cnt=0.

## Timing
- {an,seg} is held across edges k..k+STABLE_CYC-1. The outputs update, and upd/err are high, in the cycle following edge k+STABLE_CYC-1.
- Any change before edge k+STABLE_CYC-1 restarts the count and no capture occurs. Glitches shorter than STABLE_CYC samples are therefore rejected.
- Back-to-back digits: a new value sampled at the edge after a capture starts a fresh count. The minimum capture spacing is STABLE_CYC edges.
- A value that stays unchanged after its capture produces no further upd.
- A changed pattern on the same anode is captured again as a new event.
- An asynchronous rst mid-count clears all state immediately. The first capture after release needs STABLE_CYC fresh samples.
- upd and err are registered single-cycle pulses; there is no backpressure.

## Configuration
- SVN_HEX_EN defined: the decoder also accepts the hex glyphs 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F.
- SVN_HEX_EN undefined: those six patterns are illegal and raise err. All other behaviour is identical.

## Structure
- Package svn_pkg holds:
  - localparam segment-pattern constants SEG_0..SEG_9, SEG_A..SEG_F and SEG_BLANK (7-bit, active-low)
  - a typedef for the decode result {nib[3:0], blank, legal}
- Sub-module svn_encdr: purely combinational, CA..CG in → nib, blank and legal out, with the SVN_HEX_EN guard inside it.
- svn_scan_rdr holds the sample register, stability counter, capture logic and per-digit output registers.

## Test plan
- Reset, then idle with an=all 1 → digits=0, blank=all 1, valid=0; no upd for 100 cycles.
- an=4'b1110 and seg=8'b00100101 held for 4 cycles (STABLE_CYC=4) → digits[3:0]=2, dp[0]=0, valid[0]=1, and a single upd with upd_idx=0 in the cycle after the 4th edge.
- Scan 1,2,3,4 with DP lit on digit 2 (seg=8'b00001100), 8 cycles per digit → digits=16'h4321, dp=4'b0100, valid=4'hF, four upd pulses.
- Pattern held only 3 cycles, and an=4'b1100 held 10 cycles → no upd and no change in any output.
- seg=8'b00010001 ("A") on digit 1 → err and upd pulse and digits are unchanged without SVN_HEX_EN; digits[7:4]=4'hA with no err when SVN_HEX_EN is defined.
- rst asserted at cnt=2 during a capture → outputs return to reset values immediately; the same input after rst release needs 4 fresh samples before upd.

Source files
------------

// File: rtl/svn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : svn_pkg
// Purpose  : Shared constants and types for the seven-segment scan reader.
//            Segment patterns are {CA..CG}, active-low (0 = segment lit).
// Revision : 1.0 - initial release
// ============================================================================
package svn_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Decode result: recovered nibble, all-off flag, pattern recognised
    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       legal;
    } svn_dec_t;

endpackage
`default_nettype wire

// File: rtl/svn_encdr.sv
`default_nettype none
// ============================================================================
// Module   : svn_encdr
// Purpose  : Combinational segment-pattern decoder, {CA..CG} -> nibble,
//            blank flag and legal flag. Define SVN_HEX_EN to also accept
//            the A..F hex glyphs; otherwise they decode as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module svn_encdr
    import svn_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       blank_o,
    output logic       legal_o
);

    svn_dec_t w_dec;

    // Map each known glyph back to its value; anything else is illegal
    always_comb begin
        w_dec = '{nib: 4'h0, blank: 1'b0, legal: 1'b1};
        case (seg_i)
            SEG_0:     w_dec.nib = 4'h0;
            SEG_1:     w_dec.nib = 4'h1;
            SEG_2:     w_dec.nib = 4'h2;
            SEG_3:     w_dec.nib = 4'h3;
            SEG_4:     w_dec.nib = 4'h4;
            SEG_5:     w_dec.nib = 4'h5;
            SEG_6:     w_dec.nib = 4'h6;
            SEG_7:     w_dec.nib = 4'h7;
            SEG_8:     w_dec.nib = 4'h8;
            SEG_9:     w_dec.nib = 4'h9;
            SEG_BLANK: w_dec.blank = 1'b1;
`ifdef SVN_HEX_EN
            SEG_A:     w_dec.nib = 4'hA;
            SEG_B:     w_dec.nib = 4'hB;
            SEG_C:     w_dec.nib = 4'hC;
            SEG_D:     w_dec.nib = 4'hD;
            SEG_E:     w_dec.nib = 4'hE;
            SEG_F:     w_dec.nib = 4'hF;
`endif
            default:   w_dec.legal = 1'b0;
        endcase
    end

    assign nib_o   = w_dec.nib;
    assign blank_o = w_dec.blank;
    assign legal_o = w_dec.legal;

endmodule
`default_nettype wire

// File: rtl/svn_scan_rdr.sv
`default_nettype none
// ============================================================================
// Module   : svn_scan_rdr
// Purpose  : Seven-segment scan reader. Samples the active-low anode strobes
//            and segment lines, waits for STABLE_CYC identical samples and
//            decodes the strobed digit back into nibble / blank / dp.
//            Optional macro SVN_HEX_EN enables A..F glyph decoding.
// Revision : 1.0 - initial release
// ============================================================================
module svn_scan_rdr
    import svn_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NDIG-1:0]         an,
    input  logic [7:0]              seg,
    output logic [4*NDIG-1:0]       digits,
    output logic [NDIG-1:0]         blank,
    output logic [NDIG-1:0]         dp,
    output logic [NDIG-1:0]         valid,
    output logic                    upd,
    output logic [$clog2(NDIG)-1:0] upd_idx,
    output logic                    err
);

    localparam int              IDX_W   = $clog2(NDIG);
    localparam logic [7:0]      CNT_MAX = 8'(STABLE_CYC - 1);
    localparam logic [7:0]      CNT_CAP = 8'(STABLE_CYC - 2);
    localparam logic [NDIG-1:0] AN_ONE  = {{(NDIG-1){1'b0}}, 1'b1};

    logic [NDIG+7:0]   in_q;
    logic [7:0]        cnt_q,     cnt_d;
    logic [4*NDIG-1:0] digits_q,  digits_d;
    logic [NDIG-1:0]   blank_q,   blank_d;
    logic [NDIG-1:0]   dp_q,      dp_d;
    logic [NDIG-1:0]   valid_q,   valid_d;
    logic              upd_q,     upd_d;
    logic [IDX_W-1:0]  upd_idx_q, upd_idx_d;
    logic              err_q,     err_d;

    logic [NDIG+7:0]   w_in;
    logic              w_same;
    logic [NDIG-1:0]   w_an_n;
    logic              w_onehot;
    logic [IDX_W-1:0]  w_idx;
    logic              w_cap;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic              w_legal;

    assign w_in     = {an, seg};
    assign w_same   = (w_in == in_q);
    assign w_an_n   = ~an;
    // Exactly one anode low: nonzero with a single set bit in the inverted bus
    assign w_onehot = (w_an_n != '0) && ((w_an_n & (w_an_n - AN_ONE)) == '0);
    // Fires once per stable period: the counter saturates one past this value
    assign w_cap    = w_same && (cnt_q == CNT_CAP) && w_onehot;

    svn_encdr u_encdr (
        .seg_i   (seg[7:1]),
        .nib_o   (w_nib),
        .blank_o (w_blank),
        .legal_o (w_legal)
    );

    // Binary index of the single strobed anode
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_an_n[i]) w_idx = IDX_W'(i);
        end
    end

    // Stability counter: restart on any change, saturate once stable
    always_comb begin
        cnt_d = 8'd0;
        if (w_same) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    end

    // Capture: legal patterns update the strobed digit, illegal ones only flag
    always_comb begin
        digits_d  = digits_q;
        blank_d   = blank_q;
        dp_d      = dp_q;
        valid_d   = valid_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        err_d     = 1'b0;
        if (w_cap) begin
            upd_d     = 1'b1;
            upd_idx_d = w_idx;
            if (w_legal) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (w_an_n[i]) begin
                        digits_d[4*i +: 4] = w_nib;
                        blank_d[i]         = w_blank;
                        dp_d[i]            = ~seg[0];
                        valid_d[i]         = 1'b1;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Input sample register and stability counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q  <= '1;
            cnt_q <= 8'd0;
        end else begin
            in_q  <= w_in;
            cnt_q <= cnt_d;
        end
    end

    // Per-digit output registers and event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q  <= '0;
            blank_q   <= '1;
            dp_q      <= '0;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            dp_q      <= dp_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_q     <= err_d;
        end
    end

    assign digits  = digits_q;
    assign blank   = blank_q;
    assign dp      = dp_q;
    assign valid   = valid_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_svn_scan_rdr.sv
`default_nettype none
// ============================================================================
// Module   : tb_svn_scan_rdr
// Purpose  : Directed self-checking bench for svn_scan_rdr (NDIG=4,
//            STABLE_CYC=4). Honors SVN_HEX_EN for hex glyph expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svn_scan_rdr;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;
    int upd_seen = 0;
    int err_seen = 0;
    int upd_base;
    int err_base;

    svn_scan_rdr #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk     (clk),
        .rst     (rst),
        .an      (an),
        .seg     (seg),
        .digits  (digits),
        .blank   (blank),
        .dp      (dp),
        .valid   (valid),
        .upd     (upd),
        .upd_idx (upd_idx),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Pulse counters; at a rising edge the pulse from the prior cycle is seen
    always @(posedge clk) begin
        if (upd) upd_seen <= upd_seen + 1;
        if (err) err_seen <= err_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive a pattern at the current falling edge and hold for n cycles
    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        upd_base = upd_seen;
        err_base = err_seen;
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'hF;
        seg = 8'hFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_digits",  32'(digits),  32'h0);
        chk("rst_blank",   32'(blank),   32'hF);
        chk("rst_dp",      32'(dp),      32'h0);
        chk("rst_valid",   32'(valid),   32'h0);
        chk("rst_upd",     32'(upd),     32'h0);
        chk("rst_err",     32'(err),     32'h0);
        chk("rst_upd_idx", 32'(upd_idx), 32'h0);

        // Idle with no anode strobed: nothing captured
        mark();
        hold(4'hF, 8'hFF, 100);
        chk("idle_upd_cnt", 32'(upd_seen - upd_base), 32'd0);
        chk("idle_valid",   32'(valid),               32'h0);

        // Single capture of "2" on digit 0: upd appears after the 4th edge
        mark();
        hold(4'b1110, 8'b00100101, 3);
        chk("cap2_early_upd", 32'(upd), 32'h0);
        @(negedge clk);
        chk("cap2_upd",     32'(upd),     32'h1);
        chk("cap2_idx",     32'(upd_idx), 32'h0);
        chk("cap2_digit",   32'(digits[3:0]), 32'h2);
        chk("cap2_dp",      32'(dp[0]),   32'h0);
        chk("cap2_valid",   32'(valid),   32'h1);
        chk("cap2_blank",   32'(blank),   32'hE);
        repeat (6) @(negedge clk);
        chk("cap2_single",  32'(upd_seen - upd_base), 32'd1);

        // Full scan 1,2,3(dp),4
        mark();
        hold(4'b1110, 8'b10011111, 8);
        hold(4'b1101, 8'b00100101, 8);
        hold(4'b1011, 8'b00001100, 8);
        hold(4'b0111, 8'b10011001, 8);
        chk("scan_upd_cnt", 32'(upd_seen - upd_base), 32'd4);
        chk("scan_digits",  32'(digits),  32'h4321);
        chk("scan_dp",      32'(dp),      32'h4);
        chk("scan_valid",   32'(valid),   32'hF);
        chk("scan_blank",   32'(blank),   32'h0);
        chk("scan_idx",     32'(upd_idx), 32'h3);

        // Short glitch and a ghost (two anodes low) are ignored
        mark();
        hold(4'b1110, 8'b00000001, 3);
        hold(4'b1100, 8'b00000001, 10);
        hold(4'hF,    8'hFF,       4);
        chk("glitch_upd_cnt", 32'(upd_seen - upd_base), 32'd0);
        chk("glitch_digits",  32'(digits), 32'h4321);
        chk("glitch_dp",      32'(dp),     32'h4);

        // Hex "A" on digit 1
        mark();
        hold(4'b1101, 8'b00010001, 8);
        chk("hexA_upd_cnt", 32'(upd_seen - upd_base), 32'd1);
        chk("hexA_idx",     32'(upd_idx), 32'h1);
`ifdef SVN_HEX_EN
        chk("hexA_err_cnt", 32'(err_seen - err_base), 32'd0);
        chk("hexA_digits",  32'(digits), 32'h43A1);
`else
        chk("hexA_err_cnt", 32'(err_seen - err_base), 32'd1);
        chk("hexA_digits",  32'(digits), 32'h4321);
`endif

        // Pattern illegal in every build: err, outputs untouched
        mark();
        hold(4'b1011, 8'b11111101, 3);
        @(negedge clk);
        chk("ill_upd",  32'(upd), 32'h1);
        chk("ill_err",  32'(err), 32'h1);
        chk("ill_idx",  32'(upd_idx), 32'h2);
        chk("ill_dp",   32'(dp), 32'h4);
        repeat (3) @(negedge clk);
        chk("ill_err_cnt", 32'(err_seen - err_base), 32'd1);

        // Blank on digit 3 (DP off): nibble cleared, blank set
        hold(4'b0111, 8'hFF, 8);
        chk("blank_digit", 32'(digits[15:12]), 32'h0);
        chk("blank_flag",  32'(blank), 32'h8);
        chk("blank_valid", 32'(valid), 32'hF);

        // Asynchronous reset mid-count
        hold(4'hF, 8'hFF, 4);
        mark();
        hold(4'b1110, 8'b01001001, 3);
        #1 rst = 1'b1;
        #1;
        chk("arst_digits", 32'(digits), 32'h0);
        chk("arst_blank",  32'(blank),  32'hF);
        chk("arst_valid",  32'(valid),  32'h0);
        chk("arst_dp",     32'(dp),     32'h0);
        @(negedge clk);
        rst = 1'b0;
        mark();
        repeat (3) @(negedge clk);
        chk("arst_early_upd", 32'(upd), 32'h0);
        @(negedge clk);
        chk("arst_upd",   32'(upd),         32'h1);
        chk("arst_digit", 32'(digits[3:0]), 32'h5);
        repeat (3) @(negedge clk);
        chk("arst_upd_cnt", 32'(upd_seen - upd_base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
